// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller.
//
// Contents:
//   u3_t / u4_t / u8_t / u64_t - fixed-width helper types
//   MemMode*                   - access mode encodings, shared by loads and stores
//   mac_state_t                - controller FSM states
//   mode_to_size()             - access mode to log2(bytes); reserved modes act as d
package mem_access_ctrl_pkg;

  typedef logic [2:0]  u3_t;
  typedef logic [3:0]  u4_t;
  typedef logic [7:0]  u8_t;
  typedef logic [63:0] u64_t;

  localparam u4_t MemModeB  = 4'b0000;
  localparam u4_t MemModeH  = 4'b0001;
  localparam u4_t MemModeW  = 4'b0010;
  localparam u4_t MemModeD  = 4'b0011;
  localparam u4_t MemModeBu = 4'b0100;
  localparam u4_t MemModeHu = 4'b0101;
  localparam u4_t MemModeWu = 4'b0110;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } mac_state_t;

  // Signedness does not change the bus access size; anything unlisted is a doubleword.
  function automatic u3_t mode_to_size(u4_t mode);
    u3_t size;
    case (mode)
      MemModeB, MemModeBu: size = 3'd0;
      MemModeH, MemModeHu: size = 3'd1;
      MemModeW, MemModeWu: size = 3'd2;
      default:             size = 3'd3;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_gen.sv
// Byte-lane generator for a single memory access (purely combinational).
//
// Ports:
//   mode_i       - access mode (b/h/w/d and unsigned variants)
//   off_i        - byte offset inside the doubleword, addr[2:0]
//   wdata_i      - right-aligned store data
//   size_o       - log2 of access bytes (0..3)
//   strobe_o     - byte-lane enables for the access
//   wdata_o      - store data shifted into its byte lane
//   misaligned_o - offset is not a multiple of the access size
module mem_lane_gen
  import mem_access_ctrl_pkg::*;
(
  input  u4_t  mode_i,
  input  u3_t  off_i,
  input  u64_t wdata_i,
  output u3_t  size_o,
  output u8_t  strobe_o,
  output u64_t wdata_o,
  output logic misaligned_o
);

  u8_t         lane_mask;
  u3_t         align_mask;
  logic [15:0] strobe_wide;

  always_comb begin
    size_o     = mode_to_size(mode_i);
    lane_mask  = 8'hFF;
    align_mask = 3'b111;
    unique case (size_o)
      3'd0: begin
        lane_mask  = 8'h01;
        align_mask = 3'b000;
      end
      3'd1: begin
        lane_mask  = 8'h03;
        align_mask = 3'b001;
      end
      3'd2: begin
        lane_mask  = 8'h0F;
        align_mask = 3'b011;
      end
      default: begin
        lane_mask  = 8'hFF;
        align_mask = 3'b111;
      end
    endcase

    // Shift in a wider vector so lanes past byte 7 fall off instead of wrapping.
    strobe_wide  = {8'h00, lane_mask} << off_i;
    strobe_o     = strobe_wide[7:0];
    misaligned_o = |(off_i & align_mask);
    wdata_o      = wdata_i << {off_i, 3'b000};
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the memory stage.
//
// Accepts one load/store at a time, faults misaligned accesses without touching
// the bus, drives size/strobe/lane-shifted data onto the bus, captures the raw
// 64-bit read data and hands it downstream with the original address and mode.
//
// Ports:
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   req_*                - pipeline request (valid/ready, write, addr, wdata, mode)
//   bus_valid_o .. _wdata_o - bus request fields, held stable until bus_addr_ok_i
//   bus_addr_ok_i        - bus accepted the request
//   bus_data_ok_i        - bus completed, bus_rdata_i valid this cycle
//   resp_*               - response (valid/ready, addr, mode, write, raw rdata, fault)
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  u64_t              req_wdata_i,
  input  u4_t               req_mode_i,

  output logic              bus_valid_o,
  output logic              bus_write_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output u3_t               bus_size_o,
  output u8_t               bus_strobe_o,
  output u64_t              bus_wdata_o,
  input  logic              bus_addr_ok_i,
  input  logic              bus_data_ok_i,
  input  u64_t              bus_rdata_i,

  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [ADDR_W-1:0] resp_addr_o,
  output u4_t               resp_mode_o,
  output logic              resp_write_o,
  output u64_t              resp_rdata_o,
  output logic              resp_misaligned_o
);

  mac_state_t        state_q;
  logic              req_ready_q;
  logic              bus_valid_q;
  logic              resp_valid_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  u4_t               mode_q;
  u3_t               size_q;
  u8_t               strobe_q;
  u64_t              wdata_q;
  u64_t              rdata_q;
  logic              misaligned_q;

  u3_t               lane_size;
  u8_t               lane_strobe;
  u64_t              lane_wdata;
  logic              lane_misaligned;

  mem_lane_gen u_lane_gen (
    .mode_i       (req_mode_i),
    .off_i        (req_addr_i[2:0]),
    .wdata_i      (req_wdata_i),
    .size_o       (lane_size),
    .strobe_o     (lane_strobe),
    .wdata_o      (lane_wdata),
    .misaligned_o (lane_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b1;
      bus_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      mode_q       <= '0;
      size_q       <= '0;
      strobe_q     <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            write_q      <= req_write_i;
            addr_q       <= req_addr_i;
            mode_q       <= req_mode_i;
            size_q       <= lane_size;
            strobe_q     <= req_write_i ? lane_strobe : '0;
            wdata_q      <= lane_wdata;
            misaligned_q <= lane_misaligned;
            // Stores and faults report zero data, so clear any stale capture here.
            rdata_q      <= '0;
            req_ready_q  <= 1'b0;
            if (lane_misaligned) begin
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else begin
              bus_valid_q <= 1'b1;
              state_q     <= StReq;
            end
          end
        end

        StReq: begin
          if (bus_addr_ok_i) begin
            bus_valid_q <= 1'b0;
            if (bus_data_ok_i) begin
              if (!write_q) rdata_q <= bus_rdata_i;
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end else begin
              state_q <= StWait;
            end
          end
        end

        StWait: begin
          if (bus_data_ok_i) begin
            if (!write_q) rdata_q <= bus_rdata_i;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end
        end

        StResp: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o       = req_ready_q;

  assign bus_valid_o       = bus_valid_q;
  assign bus_write_o       = write_q;
  assign bus_addr_o        = addr_q;
  assign bus_size_o        = size_q;
  assign bus_strobe_o      = strobe_q;
  assign bus_wdata_o       = wdata_q;

  assign resp_valid_o      = resp_valid_q;
  assign resp_addr_o       = addr_q;
  assign resp_mode_o       = mode_q;
  assign resp_write_o      = write_q;
  assign resp_rdata_o      = rdata_q;
  assign resp_misaligned_o = misaligned_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver pushes expected bus and
// response records, a bus responder and a response monitor pop and compare.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [3:0]  req_mode;
  logic        bus_valid, bus_write;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [2:0]  bus_size;
  logic [7:0]  bus_strobe;
  logic        bus_addr_ok, bus_data_ok;
  logic        resp_valid, resp_ready, resp_write, resp_mis;
  logic [63:0] resp_addr, resp_rdata;
  logic [3:0]  resp_mode;

  mem_access_ctrl #(.ADDR_W(64)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_write_i       (req_write),
    .req_addr_i        (req_addr),
    .req_wdata_i       (req_wdata),
    .req_mode_i        (req_mode),
    .bus_valid_o       (bus_valid),
    .bus_write_o       (bus_write),
    .bus_addr_o        (bus_addr),
    .bus_size_o        (bus_size),
    .bus_strobe_o      (bus_strobe),
    .bus_wdata_o       (bus_wdata),
    .bus_addr_ok_i     (bus_addr_ok),
    .bus_data_ok_i     (bus_data_ok),
    .bus_rdata_i       (bus_rdata),
    .resp_valid_o      (resp_valid),
    .resp_ready_i      (resp_ready),
    .resp_addr_o       (resp_addr),
    .resp_mode_o       (resp_mode),
    .resp_write_o      (resp_write),
    .resp_rdata_o      (resp_rdata),
    .resp_misaligned_o (resp_mis)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int unsigned acc_cyc = 0;

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
  } bus_exp_t;

  typedef struct {
    int          ad;  // extra cycles bus_valid is held before addr_ok
    int          dd;  // cycles from addr_ok to data_ok (0 = same cycle)
    logic [63:0] rd;
  } bus_plan_t;

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  mode;
    logic        write;
    logic [63:0] rdata;
    logic        mis;
    int          lat;
    int          stall;
  } resp_exp_t;

  bus_exp_t  bus_q[$];
  bus_plan_t plan_q[$];
  resp_exp_t resp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_bus_valid"}, bus_valid, 0);
    chk({tag, "_bus_write"}, bus_write, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_size"}, bus_size, 0);
    chk({tag, "_bus_strobe"}, bus_strobe, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_addr"}, resp_addr, 0);
    chk({tag, "_resp_mode"}, resp_mode, 0);
    chk({tag, "_resp_write"}, resp_write, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_resp_mis"}, resp_mis, 0);
  endtask

  // Reference rules: size from mode, natural alignment, lane placement by offset.
  function automatic int model_size(input logic [3:0] mode);
    case (mode)
      4'd0, 4'd4: return 0;
      4'd1, 4'd5: return 1;
      4'd2, 4'd6: return 2;
      default:    return 3;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic wr, input logic [63:0] addr, input logic [3:0] mode,
                       input logic [63:0] wdata, input int ad, input int dd,
                       input logic [63:0] rd, input int stall, input bit expect_resp);
    int        sz, off, nbytes, strobe_int, n;
    bit        mis;
    bus_exp_t  be;
    bus_plan_t bp;
    resp_exp_t re;
    sz     = model_size(mode);
    off    = int'(addr[2:0]);
    nbytes = 1 << sz;
    mis    = (off % nbytes) != 0;
    strobe_int = ((1 << nbytes) - 1) << off;
    if (!mis) begin
      be.write  = wr;
      be.addr   = addr;
      be.size   = 3'(sz);
      be.strobe = wr ? strobe_int[7:0] : 8'h00;
      be.wdata  = wdata << (8 * off);
      bp.ad = ad;
      bp.dd = dd;
      bp.rd = rd;
      bus_q.push_back(be);
      plan_q.push_back(bp);
    end
    if (expect_resp) begin
      re.addr  = addr;
      re.mode  = mode;
      re.write = wr;
      re.rdata = (wr || mis) ? 64'h0 : rd;
      re.mis   = mis;
      re.lat   = mis ? 1 : 2 + ad + dd;
      re.stall = stall;
      resp_q.push_back(re);
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_mode  = mode;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout: req_ready=0 after 200 cycles, expected 1");
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      acc_cyc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  // Bus responder: consumes one plan per observed bus request.
  initial begin : bus_responder
    bus_exp_t  e;
    bus_plan_t p;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 64'hDEAD_BEEF_0BAD_F00D;
    forever begin
      @(negedge clk);
      if (rst_n && bus_valid) begin
        if (bus_q.size() == 0 || plan_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_unexpected: bus_valid=1 expected 0 (no request pending)");
          bus_addr_ok = 1'b1;
          @(negedge clk);
          bus_addr_ok = 1'b0;
        end else begin
          e = bus_q.pop_front();
          p = plan_q.pop_front();
          chk("bus_write", bus_write, e.write);
          chk("bus_addr", bus_addr, e.addr);
          chk("bus_size", bus_size, e.size);
          chk("bus_strobe", bus_strobe, e.strobe);
          chk("bus_wdata", bus_wdata, e.wdata);
          for (int i = 0; i < p.ad; i++) begin
            @(negedge clk);
            chk("bus_valid_hold", bus_valid, 1);
            chk("bus_strobe_hold", bus_strobe, e.strobe);
            chk("bus_addr_hold", bus_addr, e.addr);
          end
          bus_addr_ok = 1'b1;
          if (p.dd == 0) begin
            bus_data_ok = 1'b1;
            bus_rdata   = p.rd;
          end
          @(negedge clk);
          bus_addr_ok = 1'b0;
          bus_data_ok = 1'b0;
          bus_rdata   = {$urandom, $urandom};
          if (rst_n) chk("bus_valid_drop", bus_valid, 0);
          if (p.dd > 0) begin
            repeat (p.dd - 1) @(negedge clk);
            bus_data_ok = 1'b1;
            bus_rdata   = p.rd;
            @(negedge clk);
            bus_data_ok = 1'b0;
            bus_rdata   = {$urandom, $urandom};
          end
        end
      end
    end
  end

  // Response monitor: compares every cycle resp_valid is high, so held fields are checked too.
  initial begin : resp_monitor
    resp_exp_t e;
    bit        fresh;
    int        stall_left;
    fresh      = 1'b1;
    stall_left = 0;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !resp_valid) begin
        resp_ready = 1'b0;
      end else if (resp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected: resp_valid=1 expected 0 (addr 0x%0h)", resp_addr);
        resp_ready = 1'b1;
      end else begin
        e = resp_q[0];
        if (fresh) begin
          chk("resp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
          stall_left = e.stall;
          fresh = 1'b0;
        end
        chk("resp_addr", resp_addr, e.addr);
        chk("resp_mode", resp_mode, e.mode);
        chk("resp_write", resp_write, e.write);
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_mis", resp_mis, e.mis);
        chk("req_ready_in_resp", req_ready, 0);
        if (stall_left > 0) begin
          resp_ready = 1'b0;
          stall_left--;
        end else begin
          resp_ready = ($urandom_range(0, 2) != 0);
        end
        if (resp_ready) begin
          void'(resp_q.pop_front());
          fresh = 1'b1;
        end
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((resp_q.size() != 0 || bus_q.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (resp_q.size() != 0 || bus_q.size() != 0 || !req_ready) begin
      failures++;
      $display("FAIL %s_drain: %0d responses / %0d bus requests outstanding, expected 0",
               tag, resp_q.size(), bus_q.size());
    end
  endtask

  initial begin : driver
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_mode  = '0;
    repeat (2) @(negedge clk);
    reset_checks("por");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    // Word load answered in the first bus cycle.
    issue(1'b0, 64'h1004, 4'b0010, 64'h0, 0, 0, 64'h8000_0001_1234_5678, 0, 1'b1);
    // Byte store with slow address and data phases.
    issue(1'b1, 64'h2003, 4'b0000, 64'hAB, 2, 2, 64'h5555_5555_5555_5555, 0, 1'b1);
    // Misaligned halfword: faults without a bus transaction.
    issue(1'b0, 64'h3001, 4'b0001, 64'h0, 0, 0, 64'h0, 0, 1'b1);
    // Reserved mode behaves as a doubleword; doubleword store fills all lanes.
    issue(1'b0, 64'h4000, 4'b1111, 64'h0, 1, 0, 64'h0123_4567_89AB_CDEF, 0, 1'b1);
    issue(1'b1, 64'h4000, 4'b0011, 64'hFEDC_BA98_7654_3210, 0, 1, 64'h0, 0, 1'b1);
    // Backpressure: next request is presented while the response is held.
    issue(1'b0, 64'h6006, 4'b0101, 64'h0, 0, 0, 64'hCAFE_F00D_1357_2468, 5, 1'b1);
    issue(1'b1, 64'h6006, 4'b0001, 64'hBEEF, 0, 0, 64'h0, 0, 1'b1);
    drain("directed");

    // Reset while waiting for data; the late data_ok must not produce a response.
    issue(1'b0, 64'h5000, 4'b0011, 64'h0, 0, 10, 64'h1111_2222_3333_4444, 0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_checks("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post_rst_resp_valid", resp_valid, 0);
      chk("post_rst_bus_valid", bus_valid, 0);
    end
    chk("post_rst_req_ready", req_ready, 1);

    for (int i = 0; i < 60; i++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), {$urandom, $urandom},
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), {$urandom, $urandom},
            int'($urandom_range(0, 2)), 1'b1);
    end
    drain("random");
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
